// File: rtl/hamur_yogurucu.sv
// hamur_yogurucu: sequential dough processor. Accepts one job per basla
// handshake, computes weight un*su+tuz with a shift-add multiplier, grades
// thickness, runs a kneading timer proportional to weight and an optional
// yeast-rest timer, then pulses bitti for one cycle.
// Optional feature macro: HAMUR_ASIRI_YUK_EN (overweight detection, hata port).
module hamur_yogurucu #(
  parameter int unsigned UN_W               = 6,
  parameter int unsigned SU_W               = 8,
  parameter int unsigned TUZ_W              = 3,
  parameter int unsigned MAYALI_ESIK_KALIN  = 10000,
  parameter int unsigned MAYALI_ESIK_ORTA   = 5000,
  parameter int unsigned MAYASIZ_ESIK_KALIN = 8000,
  parameter int unsigned MAYASIZ_ESIK_ORTA  = 4000,
  parameter int unsigned TUZ_ESIK           = 5,
  parameter int unsigned YOGURMA_KAYDIR     = 10,
  parameter int unsigned MAYA_SURE          = 16
`ifdef HAMUR_ASIRI_YUK_EN
  ,
  parameter int unsigned AZAMI_AGIRLIK      = 12000
`endif
) (
  input  logic                 saat,
  input  logic                 reset,
  input  logic                 basla,
  input  logic                 iptal,
  input  logic [UN_W-1:0]      un_miktari,
  input  logic [SU_W-1:0]      su_miktari,
  input  logic [TUZ_W-1:0]     tuz_miktari,
  input  logic                 maya,
  output logic                 hazir,
  output logic                 mesgul,
  output logic [UN_W+SU_W:0]   agirlik,
  output logic [1:0]           kalinlik,
  output logic                 mayali,
  output logic                 tuzlu,
  output logic                 bitti
`ifdef HAMUR_ASIRI_YUK_EN
  ,
  output logic                 hata
`endif
);

  localparam int unsigned AW = UN_W + SU_W + 1;
  localparam int unsigned BW = (UN_W > 1) ? $clog2(UN_W) : 1;

  typedef enum logic [2:0] {
    BOSTA,
    CARP,
    SINIFLA,
    YOGUR,
    MAYALAN,
    BITTI
  } durum_t;

  durum_t            durum, durum_n;
  logic              kabul;
  logic [UN_W-1:0]   un_r;
  logic [SU_W-1:0]   su_r;
  logic [TUZ_W-1:0]  tuz_r;
  logic              maya_r;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     kismi_top;
  logic [BW-1:0]     bit_sayac;
  logic              son_bit;
  logic [31:0]       sayac;
  logic [31:0]       acc_32;
  logic [AW-1:0]     k_ham;
  logic [31:0]       k_deger;
  logic [1:0]        kal_hesap;
  logic              tuz_hesap;
  logic              asiri;

  assign son_bit = (bit_sayac == BW'(UN_W - 1));
  assign acc_32  = 32'(acc);
  assign k_ham   = acc >> YOGURMA_KAYDIR;
  assign k_deger = (k_ham == '0) ? 32'd1 : 32'(k_ham);
  assign tuz_hesap = (32'(tuz_r) >= TUZ_ESIK);

`ifdef HAMUR_ASIRI_YUK_EN
  assign asiri = (acc_32 > AZAMI_AGIRLIK);
`else
  assign asiri = 1'b0;
`endif

  // Partial product for the current flour bit, plus salt on the last bit.
  always_comb begin
    kismi_top = '0;
    if (un_r[bit_sayac])
      kismi_top = AW'(su_r) << bit_sayac;
    if (son_bit)
      kismi_top = kismi_top + AW'(tuz_r);
  end

  // Thickness grade from the finished weight and the latched yeast flag.
  always_comb begin
    kal_hesap = 2'd0;
    if (maya_r) begin
      if (acc_32 >= MAYALI_ESIK_KALIN)      kal_hesap = 2'd2;
      else if (acc_32 >= MAYALI_ESIK_ORTA)  kal_hesap = 2'd1;
    end else begin
      if (acc_32 >= MAYASIZ_ESIK_KALIN)     kal_hesap = 2'd2;
      else if (acc_32 >= MAYASIZ_ESIK_ORTA) kal_hesap = 2'd1;
    end
    if (asiri) kal_hesap = 2'd3;
  end

  // State register.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) durum <= BOSTA;
    else        durum <= durum_n;
  end

  // Next-state and handshake outputs; abort overrides every transition
  // and also masks the done pulse.
  always_comb begin
    durum_n = durum;
    hazir   = 1'b0;
    mesgul  = 1'b1;
    bitti   = 1'b0;
    kabul   = 1'b0;
    case (durum)
      BOSTA: begin
        hazir  = 1'b1;
        mesgul = 1'b0;
        if (basla && !iptal) begin
          kabul   = 1'b1;
          durum_n = CARP;
        end
      end
      CARP:    if (son_bit) durum_n = SINIFLA;
      SINIFLA: durum_n = asiri ? BITTI : YOGUR;
      YOGUR:   if (sayac == 32'd1) durum_n = maya_r ? MAYALAN : BITTI;
      MAYALAN: if (sayac == 32'd1) durum_n = BITTI;
      BITTI: begin
        bitti   = 1'b1;
        durum_n = BOSTA;
      end
      default: durum_n = BOSTA;
    endcase
    if (iptal && (durum != BOSTA)) begin
      durum_n = BOSTA;
      bitti   = 1'b0;
    end
  end

  // Datapath: input latch, multiplier accumulator, timers and held results.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      un_r      <= '0;
      su_r      <= '0;
      tuz_r     <= '0;
      maya_r    <= 1'b0;
      acc       <= '0;
      bit_sayac <= '0;
      sayac     <= '0;
      agirlik   <= '0;
      kalinlik  <= '0;
      mayali    <= 1'b0;
      tuzlu     <= 1'b0;
`ifdef HAMUR_ASIRI_YUK_EN
      hata      <= 1'b0;
`endif
    end else if (!(iptal && (durum != BOSTA))) begin
      case (durum)
        BOSTA: begin
          if (kabul) begin
            un_r      <= un_miktari;
            su_r      <= su_miktari;
            tuz_r     <= tuz_miktari;
            maya_r    <= maya;
            acc       <= '0;
            bit_sayac <= '0;
          end
        end
        CARP: begin
          acc       <= acc + kismi_top;
          bit_sayac <= bit_sayac + 1'b1;
        end
        SINIFLA: begin
          agirlik  <= acc;
          kalinlik <= kal_hesap;
          mayali   <= maya_r;
          tuzlu    <= tuz_hesap;
          sayac    <= k_deger;
`ifdef HAMUR_ASIRI_YUK_EN
          hata     <= asiri;
`endif
        end
        YOGUR: begin
          if (sayac == 32'd1) sayac <= MAYA_SURE;
          else                sayac <= sayac - 32'd1;
        end
        MAYALAN: sayac <= sayac - 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamur_yogurucu.sv
// Self-checking bench for hamur_yogurucu: directed jobs plus randomized jobs
// checked cycle by cycle against an arithmetic reference model.
module tb_hamur_yogurucu;

  localparam int UN_W = 6;
  localparam int SU_W = 8;
  localparam int TUZ_W = 3;
  localparam int M_SURE = 16;

  logic                saat = 1'b0;
  logic                reset = 1'b0;
  logic                basla = 1'b0;
  logic                iptal = 1'b0;
  logic [UN_W-1:0]     un_miktari = '0;
  logic [SU_W-1:0]     su_miktari = '0;
  logic [TUZ_W-1:0]    tuz_miktari = '0;
  logic                maya = 1'b0;
  logic                hazir, mesgul, mayali, tuzlu, bitti;
  logic [UN_W+SU_W:0]  agirlik;
  logic [1:0]          kalinlik;
`ifdef HAMUR_ASIRI_YUK_EN
  logic                hata;
`endif

  int tests = 0;
  int failed = 0;
  int h_w = 0, h_kal = 0, h_may = 0, h_tuz = 0, h_hata = 0;

  hamur_yogurucu #(
    .UN_W(UN_W), .SU_W(SU_W), .TUZ_W(TUZ_W),
    .MAYALI_ESIK_KALIN(10000), .MAYALI_ESIK_ORTA(5000),
    .MAYASIZ_ESIK_KALIN(8000), .MAYASIZ_ESIK_ORTA(4000),
    .TUZ_ESIK(5), .YOGURMA_KAYDIR(10), .MAYA_SURE(M_SURE)
  ) dut (
    .saat(saat), .reset(reset), .basla(basla), .iptal(iptal),
    .un_miktari(un_miktari), .su_miktari(su_miktari),
    .tuz_miktari(tuz_miktari), .maya(maya),
    .hazir(hazir), .mesgul(mesgul), .agirlik(agirlik),
    .kalinlik(kalinlik), .mayali(mayali), .tuzlu(tuzlu), .bitti(bitti)
`ifdef HAMUR_ASIRI_YUK_EN
    , .hata(hata)
`endif
  );

  always #5 saat = ~saat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
    tests++;
    if (gozlenen !== beklenen) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic sonuc_kontrol(input string on);
    kontrol({on, "_agirlik"}, int'(agirlik), h_w);
    kontrol({on, "_kalinlik"}, int'(kalinlik), h_kal);
    kontrol({on, "_mayali"}, int'(mayali), h_may);
    kontrol({on, "_tuzlu"}, int'(tuzlu), h_tuz);
`ifdef HAMUR_ASIRI_YUK_EN
    kontrol({on, "_hata"}, int'(hata), h_hata);
`endif
  endtask

  task automatic hazir_bekle();
    int bekle = 0;
    while (!hazir && bekle < 100) begin
      @(posedge saat); #1;
      bekle++;
    end
    if (bekle >= 100) kontrol("hazir_bekle", int'(hazir), 1);
  endtask

  // One job; abort_at / dup_at name the cycle in which iptal / a second basla
  // is held high (-1 = none). Expected behaviour comes from plain arithmetic.
  task automatic is_yap(input int u, input int s, input int t, input int m,
                        input int abort_at_in, input int dup_at);
    int w, kal, tz, k, lat, e_hata, abort_at;
    w = u * s + t;
    if (m != 0) kal = (w >= 10000) ? 2 : ((w >= 5000) ? 1 : 0);
    else        kal = (w >= 8000) ? 2 : ((w >= 4000) ? 1 : 0);
    tz = (t >= 5) ? 1 : 0;
    k = w / 1024;
    if (k == 0) k = 1;
    lat = UN_W + 1 + k + ((m != 0) ? M_SURE : 0);
    e_hata = 0;
`ifdef HAMUR_ASIRI_YUK_EN
    if (w > 12000) begin
      kal = 3; lat = UN_W + 1; e_hata = 1;
    end
`endif
    abort_at = (abort_at_in >= lat) ? -1 : abort_at_in;
    hazir_bekle();
    @(negedge saat);
    un_miktari = 6'(u); su_miktari = 8'(s); tuz_miktari = 3'(t); maya = (m != 0);
    basla = 1'b1;
    @(posedge saat); #1;
    basla = 1'b0;
    kontrol("c0_hazir", int'(hazir), 0);
    kontrol("c0_bitti", int'(bitti), 0);
    for (int n = 1; n <= lat + 1; n++) begin
      basla = (n - 1 == dup_at);
      iptal = (n - 1 == abort_at);
      @(posedge saat); #1;
      if (n - 1 == abort_at) begin
        basla = 1'b0;
        iptal = 1'b0;
        kontrol("iptal_hazir", int'(hazir), 1);
        kontrol("iptal_bitti", int'(bitti), 0);
        sonuc_kontrol("iptal");
        return;
      end
      if (n == UN_W + 1) begin
        h_w = w; h_kal = kal; h_may = m; h_tuz = tz; h_hata = e_hata;
      end
      kontrol("bitti", int'(bitti), int'(n == lat));
      kontrol("hazir", int'(hazir), int'(n > lat));
      kontrol("mesgul", int'(mesgul), int'(n <= lat));
      sonuc_kontrol("tut");
    end
    basla = 1'b0;
  endtask

  task automatic sifir_kontrol(input string on);
    kontrol({on, "_hazir"}, int'(hazir), 1);
    kontrol({on, "_mesgul"}, int'(mesgul), 0);
    kontrol({on, "_bitti"}, int'(bitti), 0);
    sonuc_kontrol(on);
  endtask

  initial begin
    int ab, dp;
    // power-on reset
    #1;
    sifir_kontrol("reset");
    repeat (2) @(negedge saat);
    reset = 1'b1;
    @(posedge saat); #1;
    sifir_kontrol("reset_sonra");

    // directed jobs
    is_yap(50, 200, 6, 1, -1, -1);
    is_yap(20, 200, 3, 0, -1, -1);
    is_yap(0, 255, 2, 1, -1, -1);
    is_yap(50, 200, 6, 1, -1, 3);
    is_yap(20, 200, 3, 0, -1, 10);
    is_yap(63, 255, 7, 0, -1, -1);

    // basla together with iptal in BOSTA starts nothing
    @(negedge saat);
    basla = 1'b1; iptal = 1'b1;
    @(posedge saat); #1;
    basla = 1'b0; iptal = 1'b0;
    kontrol("basla_iptal_hazir", int'(hazir), 1);
    @(posedge saat); #1;
    kontrol("basla_iptal_mesgul", int'(mesgul), 0);

    // abort in cycle 8, then reset in the middle of the next job
    is_yap(50, 200, 6, 1, 8, -1);
    hazir_bekle();
    @(negedge saat);
    un_miktari = 6'd20; su_miktari = 8'd200; tuz_miktari = 3'd3; maya = 1'b0;
    basla = 1'b1;
    @(posedge saat); #1;
    basla = 1'b0;
    repeat (8) @(posedge saat);
    #3;
    reset = 1'b0;
    #1;
    h_w = 0; h_kal = 0; h_may = 0; h_tuz = 0; h_hata = 0;
    sifir_kontrol("orta_reset");
    repeat (2) @(posedge saat);
    #1;
    sifir_kontrol("orta_reset_tut");
    @(negedge saat);
    reset = 1'b1;
    @(posedge saat); #1;
    sifir_kontrol("orta_reset_sonra");

    // randomized jobs
    for (int i = 0; i < 30; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      dp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
      is_yap(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), ab, dp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
